// File: rtl/tick_bcd_counter.sv
// tick_bcd_counter: four-digit BCD event counter advanced by rising edges of
// the TICK square wave, with START/STOP/CLR run control.
// Build option: define TICK_SYNC_EN when TICK comes from another clock domain.
// That adds a two-flop synchronizer ahead of the edge detector, so TICK-to-BCD
// latency is 3 CLK edges instead of 1.
//
// state | meaning
// IDLE  | count held at 0000, waiting for START
// RUN   | each detected tick adds TICK_STEP
// PAUSE | count held, ticks discarded, START resumes
// DONE  | saturated at 9999 (WRAP=0 only), OVF high, only CLR/RST leave
module tick_bcd_counter #(
  parameter int WRAP      = 1,  // 1: wrap past 9999 with OVF pulse, 0: saturate
  parameter int TICK_STEP = 1   // BCD increment per tick, 1..9
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        TICK,
  input  logic        START,
  input  logic        STOP,
  input  logic        CLR,
  output logic [15:0] BCD,
  output logic        RUN,
  output logic        OVF
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic       WRAP_EN = (WRAP != 0);
  localparam logic [3:0] STEP    = TICK_STEP[3:0];

  // Adds a single-digit step to a 4-digit BCD value. Bit 16 is the carry out
  // of the thousands digit.
  function automatic logic [16:0] bcd_add(input logic [15:0] v, input logic [3:0] step);
    logic [4:0]  s;
    logic        c;
    logic [15:0] r;
    c = 1'b0;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, v[i*4 +: 4]} + {1'b0, ((i == 0) ? step : 4'd0)} + {4'd0, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[i*4 +: 4] = s[3:0];
    end
    return {c, r};
  endfunction

  logic tick_c;      // conditioned TICK level seen by the edge detector
  logic tick_valid;  // tick_c reflects a post-reset TICK sample

`ifdef TICK_SYNC_EN
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] fill_q, fill_d;

  // Synchronizer next-state; fill tracks when the chain holds real samples.
  always_comb begin
    sync1_d = TICK;
    sync2_d = sync1_q;
    fill_d  = {fill_q[0], 1'b1};
  end

  // Two-flop synchronizer and fill tracker.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fill_q  <= 2'b00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      fill_q  <= fill_d;
    end
  end

  assign tick_c     = sync2_q;
  assign tick_valid = fill_q[1];
`else
  assign tick_c     = TICK;
  assign tick_valid = 1'b1;
`endif

  // Edge detector. arm_q stays low after reset until TICK has been seen low,
  // so a TICK already high at reset release cannot produce a tick.
  logic tick_prev_q, tick_prev_d;
  logic arm_q, arm_d;
  logic tick_pulse;

  // Edge detector next-state and one-cycle tick pulse.
  always_comb begin
    tick_prev_d = tick_c;
    arm_d       = arm_q | (tick_valid & ~tick_c);
    tick_pulse  = tick_valid & arm_q & tick_c & ~tick_prev_q;
  end

  // Edge detector registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_prev_q <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      tick_prev_q <= tick_prev_d;
      arm_q       <= arm_d;
    end
  end

  state_t      state_q, state_d;
  logic [15:0] bcd_q, bcd_d;
  logic        run_q, run_d;
  logic        ovf_q, ovf_d;
  logic [16:0] sum;

  // Next state, count and registered outputs; priority CLR > STOP > START > tick.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    ovf_d   = 1'b0;
    sum     = bcd_add(bcd_q, STEP);
    if (CLR) begin
      state_d = S_IDLE;
      bcd_d   = 16'h0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          bcd_d = 16'h0000;
          if (!STOP && START) state_d = S_RUN;
        end
        S_RUN: begin
          if (STOP) begin
            state_d = S_PAUSE;
          end else if (tick_pulse) begin
            if (WRAP_EN) begin
              bcd_d = sum[15:0];
              ovf_d = sum[16];
            end else if (sum[16] || (sum[15:0] == 16'h9999)) begin
              bcd_d   = 16'h9999;
              state_d = S_DONE;
            end else begin
              bcd_d = sum[15:0];
            end
          end
        end
        S_PAUSE: begin
          if (!STOP && START) state_d = S_RUN;
        end
        S_DONE: begin
          bcd_d = 16'h9999;
        end
        default: begin
          state_d = S_IDLE;
          bcd_d   = 16'h0000;
        end
      endcase
    end
    if (!WRAP_EN && (state_d == S_DONE)) ovf_d = 1'b1;
    run_d = (state_d == S_RUN);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      bcd_q   <= 16'h0000;
      run_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      run_q   <= run_d;
      ovf_q   <= ovf_d;
    end
  end

  assign BCD = bcd_q;
  assign RUN = run_q;
  assign OVF = ovf_q;

endmodule

// File: doc/tick_bcd_counter.md
TICK_BCD_COUNTER -- requirements
Module: tick_bcd_counter

Interface
REQ-001 Parameter WRAP, default 1: 1 = wrap 9999->0000 with OVF pulse; 0 = saturate at 9999 and enter DONE.
REQ-002 Parameter TICK_STEP, default 1: BCD increment per detected tick, legal 1..9.
REQ-003 CLK  input  1  single system clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 TICK  input  1  divided-frequency square wave from the upstream N_Frec divider's CLK2 output, treated as data, never as a clock.
REQ-006 START  input  1  level, sampled each CLK; starts or resumes counting.
REQ-007 STOP  input  1  level, sampled each CLK; pauses counting.
REQ-008 CLR  input  1  level, sampled each CLK; clears count to 0000 and returns to IDLE.
REQ-009 BCD  output  16  four BCD digits; [15:12] thousands, [3:0] units; registered.
REQ-010 RUN  output  1  high while state is RUN; registered.
REQ-011 OVF  output  1  one-cycle pulse on wrap (WRAP=1), or level while in DONE (WRAP=0); registered.

Function
REQ-012 States: IDLE, RUN, PAUSE, DONE; encoding is implementer's choice.
REQ-013 Tick detection: one rising edge of TICK yields exactly one internal tick pulse, one CLK wide; a TICK held high yields no further pulses.
REQ-014 Ticks are detected in every state; BCD changes only in RUN.
REQ-015 Control priority on the same cycle: CLR > STOP > START > tick.
REQ-016 IDLE: START -> RUN; STOP ignored; BCD held at 0000.
REQ-017 RUN: each tick adds TICK_STEP to BCD with per-digit decimal carry; STOP -> PAUSE, tick on that cycle discarded.
REQ-018 PAUSE: BCD held; START -> RUN; ticks discarded.
REQ-019 DONE (WRAP=0 only): BCD held at 9999, OVF high; START and STOP ignored; only CLR or RST exits, to IDLE.
REQ-020 Any state: CLR -> IDLE, BCD 0000, OVF 0, on the next edge.
REQ-021 WRAP=1 boundary: a sum exceeding 9999 keeps the low four decimal digits (9998 + 3 -> 0001) and OVF pulses high for the same cycle BCD takes the wrapped value.
REQ-022 WRAP=0 boundary: a sum reaching or exceeding 9999 loads 9999 and enters DONE on the same edge.
REQ-023 Each BCD digit shall never hold a value above 9.
REQ-024 Latency: BCD update visible N CLK edges after the first edge at which TICK is sampled high; N is set by REQ-029/REQ-030.

Reset
REQ-025 RST high forces IDLE, BCD=0000, RUN=0, OVF=0 and all tick-detect flops to 0, asynchronously.
REQ-026 RST release mid-period with TICK already high shall not generate a tick until TICK falls and rises again.
REQ-027 RST asserted mid-count discards count; no partial state survives.

Configuration
REQ-028 Macro TICK_SYNC_EN selects TICK input conditioning.
REQ-029 TICK_SYNC_EN defined: TICK passes a two-flop synchronizer before edge detection; N = 3.
REQ-030 TICK_SYNC_EN undefined: TICK feeds edge detection directly (same-clock-domain source); N = 1.

Verification
REQ-031 RST, START=1 one cycle, TICK toggling every 10 CLK, 5 rising edges -> BCD=0005, RUN=1, OVF never high.
REQ-032 WRAP=1, count to 9998, TICK_STEP=3, one tick -> BCD=0001, OVF high exactly one cycle.
REQ-033 WRAP=0, count to 9997, TICK_STEP=1, three ticks -> BCD=9999 after second tick, DONE, OVF=1, third tick and START ignored; CLR -> IDLE, BCD=0000, OVF=0.
REQ-034 RUN at 0042, STOP+START+tick on same cycle -> PAUSE, BCD=0042; later START -> RUN, next tick -> 0043.
REQ-035 TICK held high 50 CLK in RUN -> exactly one increment; latency measured 3 edges with TICK_SYNC_EN, 1 without.
REQ-036 RST asserted mid-cycle at count 0123 with TICK high, released, TICK stays high -> BCD=0000, no increment until next TICK rising edge after START.
